sm_fv_pingpong_bank: RTL

- Downstream consumer of the big feature-value bank controller's stream to the small FV banks (sos/eos/FV_data/A).
- Captures each streamed iteration of feature-value lines into one half of a two-bank ping-pong SRAM pair.
- Serves burst reads to the vertex PEs from the other half, with a single-cycle SRAM read latency.
- Drives `fill_ready`, which upstream uses to gate `stream_begin`.

---
 rtl/sm_fv_pingpong_bank_pkg.sv | 40 ++++
 rtl/sm_fv_rd_burst.sv | 142 ++++++++++++++
 rtl/sm_fv_pingpong_bank.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sm_fv_pingpong_bank_pkg.sv
// Shared constants and types for the small feature-value ping-pong bank.
// The constants reflect the system feature-value geometry. The typedefs describe
// the stream, the read requests and the read responses at system level.
package sm_fv_pingpong_bank_pkg;

  localparam int FV_DATA_W         = 64;
  localparam int FV_ADDR_W         = 8;
  localparam int FV_BANK_AW        = FV_ADDR_W - 2;
  localparam int FV_LINES_PER_NODE = 8;
  localparam int FV_LN_W           = $clog2(FV_LINES_PER_NODE);
  localparam int FV_NODE_W         = FV_BANK_AW - FV_LN_W;
  localparam int FV_TAG_W          = 2;

  typedef enum logic {F_IDLE, F_FILL}  fill_state_t;
  typedef enum logic {R_IDLE, R_BURST} rd_state_t;

  // One word of the stream arriving from the big FV bank controller
  typedef struct packed {
    logic                 sos;
    logic                 eos;
    logic [FV_DATA_W-1:0] fv_data;
    logic [FV_ADDR_W-1:0] a;
  } fv_stream_t;

  // Request from a vertex PE. A lines value of 0 requests a whole node.
  typedef struct packed {
    logic [FV_NODE_W-1:0] node;
    logic [FV_LN_W:0]     lines;
    logic [FV_TAG_W-1:0]  tag;
  } fv_rd_req_t;

  // One line of a read burst
  typedef struct packed {
    logic                 sos;
    logic                 eos;
    logic [FV_DATA_W-1:0] data;
    logic [FV_TAG_W-1:0]  tag;
  } fv_rd_rsp_t;

endpackage

// File: rtl/sm_fv_rd_burst.sv
// Read-side burst engine: accepts one request at a time, issues one SRAM read
// per cycle starting in the accept cycle, and delays the per-line flags by one
// cycle so they line up with the SRAM read data.
module sm_fv_rd_burst
  import sm_fv_pingpong_bank_pkg::*;
#(
  parameter int BANK_AW        = FV_BANK_AW,
  parameter int NODE_W         = FV_NODE_W,
  parameter int LN_W           = FV_LN_W,
  parameter int TAG_W          = FV_TAG_W,
  parameter int LINES_PER_NODE = FV_LINES_PER_NODE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req_valid,
  input  logic               i_bank_full,
  input  logic [NODE_W-1:0]  i_req_node,
  input  logic [LN_W:0]      i_req_lines,
  input  logic [TAG_W-1:0]   i_req_tag,
  input  logic               i_read_sel,
  output logic               o_req_ready,
  output logic               o_issue,
  output logic [BANK_AW-1:0] o_issue_addr,
  output logic               o_idle,
  output logic               o_multi_accept,
  output logic               o_burst_last,
  output logic               o_out_valid,
  output logic               o_out_sos,
  output logic               o_out_eos,
  output logic [TAG_W-1:0]   o_out_tag,
  output logic               o_out_bank
);

  localparam logic [LN_W:0]      ONE_L    = 1;
  localparam logic [BANK_AW-1:0] ONE_A    = 1;
  localparam logic [LN_W:0]      FULL_LEN = (LN_W+1)'(LINES_PER_NODE);

  rd_state_t          r_state, w_state_next;
  logic [BANK_AW-1:0] r_addr, w_addr_next;
  logic [LN_W:0]      r_remain, w_remain_next;
  logic [TAG_W-1:0]   r_tag, w_tag_next;

  logic               w_accept;
  logic [LN_W:0]      w_len;
  logic [BANK_AW-1:0] w_base;
  logic               w_issue_sos, w_issue_eos;
  logic [TAG_W-1:0]   w_issue_tag;

  logic               r_out_valid, r_out_sos, r_out_eos, r_out_bank;
  logic [TAG_W-1:0]   r_out_tag;

  assign o_req_ready = (r_state == R_IDLE) & i_bank_full;
  assign o_idle      = (r_state == R_IDLE);
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_len       = (i_req_lines == '0) ? FULL_LEN : i_req_lines;
  assign w_base      = {i_req_node, {LN_W{1'b0}}};

  // Next-state, issue address and per-line flags of the burst
  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_remain_next  = r_remain;
    w_tag_next     = r_tag;
    o_issue        = 1'b0;
    o_issue_addr   = r_addr;
    w_issue_sos    = 1'b0;
    w_issue_eos    = 1'b0;
    w_issue_tag    = r_tag;
    o_multi_accept = 1'b0;
    o_burst_last   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (w_accept) begin
          // Line 0 goes out in the accept cycle itself
          o_issue      = 1'b1;
          o_issue_addr = w_base;
          w_issue_sos  = 1'b1;
          w_issue_tag  = i_req_tag;
          w_tag_next   = i_req_tag;
          if (w_len == ONE_L) begin
            w_issue_eos = 1'b1;
          end else begin
            o_multi_accept = 1'b1;
            w_state_next   = R_BURST;
            w_addr_next    = w_base + ONE_A;
            w_remain_next  = w_len - ONE_L;
          end
        end
      end
      R_BURST: begin
        o_issue       = 1'b1;
        w_addr_next   = r_addr + ONE_A;
        w_remain_next = r_remain - ONE_L;
        if (r_remain == ONE_L) begin
          w_issue_eos  = 1'b1;
          o_burst_last = 1'b1;
          w_state_next = R_IDLE;
        end
      end
      default: w_state_next = R_IDLE;
    endcase
  end

  // Burst state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= R_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_tag    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_addr   <= w_addr_next;
      r_remain <= w_remain_next;
      r_tag    <= w_tag_next;
    end
  end

  // One-cycle delay of the issue flags to match the SRAM read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_sos   <= 1'b0;
      r_out_eos   <= 1'b0;
      r_out_tag   <= '0;
      r_out_bank  <= 1'b0;
    end else begin
      r_out_valid <= o_issue;
      r_out_sos   <= w_issue_sos;
      r_out_eos   <= w_issue_eos;
      r_out_tag   <= o_issue ? w_issue_tag : '0;
      r_out_bank  <= i_read_sel;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_sos   = r_out_sos;
  assign o_out_eos   = r_out_eos;
  assign o_out_tag   = r_out_tag;
  assign o_out_bank  = r_out_bank;

endmodule

// File: rtl/sm_fv_pingpong_bank.sv
// Ping-pong pair of small FV banks. Streamed iterations are captured into the
// fill bank, while vertex PEs read bursts from the other, full bank. Fill only
// touches non-full banks and reads only touch full banks, so the two sides
// never share a single-port bank in the same cycle.
module sm_fv_pingpong_bank
  import sm_fv_pingpong_bank_pkg::*;
#(
  parameter int DATA_W         = FV_DATA_W,
  parameter int ADDR_W         = FV_ADDR_W,
  parameter int BANK_AW        = FV_BANK_AW,
  parameter int LINES_PER_NODE = FV_LINES_PER_NODE,
  parameter int NODE_W         = FV_NODE_W,
  parameter int TAG_W          = FV_TAG_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              stream_sos,
  input  logic                              stream_eos,
  input  logic [DATA_W-1:0]                 stream_data,
  input  logic [ADDR_W-1:0]                 stream_addr,
  output logic                              fill_ready,
  input  logic                              rd_req_valid,
  output logic                              rd_req_ready,
  input  logic [NODE_W-1:0]                 rd_req_node,
  input  logic [$clog2(LINES_PER_NODE):0]   rd_req_lines,
  input  logic [TAG_W-1:0]                  rd_req_tag,
  input  logic                              rd_release,
  output logic                              rd_out_valid,
  output logic                              rd_out_sos,
  output logic                              rd_out_eos,
  output logic [DATA_W-1:0]                 rd_out_data,
  output logic [TAG_W-1:0]                  rd_out_tag,
  output logic [1:0]                        sram_cen,
  output logic [1:0]                        sram_wen,
  output logic [BANK_AW-1:0]                sram_addr0,
  output logic [BANK_AW-1:0]                sram_addr1,
  output logic [DATA_W-1:0]                 sram_wdata,
  input  logic [DATA_W-1:0]                 sram_rdata0,
  input  logic [DATA_W-1:0]                 sram_rdata1,
  output logic                              overflow_err
);

  localparam int LN_W = $clog2(LINES_PER_NODE);

  fill_state_t        r_fstate, w_fstate_next;
  logic [1:0]         r_full, w_full_next;
  logic               r_fill_sel, r_read_sel;
  logic               r_pend_rel, r_overflow_err;

  logic               w_fill_wr, w_fill_done, w_fill_ovf;
  logic [BANK_AW-1:0] w_fill_addr;
  logic               w_unused_addr;

  logic               w_rd_issue, w_rd_idle, w_rd_multi, w_rd_last;
  logic [BANK_AW-1:0] w_rd_addr;
  logic               w_out_bank;
  logic               w_rel_now, w_pend_set;
  logic [BANK_AW-1:0] w_bank_addr [2];

  // Only the in-bank line address is used; the upper stream bits select the big bank
  assign w_fill_addr   = stream_addr[BANK_AW-1:0];
  assign w_unused_addr = ^stream_addr[ADDR_W-1:BANK_AW];

  // Fill FSM: decides whether this stream word is written and when a bank completes
  always_comb begin
    w_fstate_next = r_fstate;
    w_fill_wr     = 1'b0;
    w_fill_done   = 1'b0;
    w_fill_ovf    = 1'b0;
    case (r_fstate)
      F_IDLE: begin
        // Words without sos are ignored, which also drops the tail of a refused stream
        if (stream_sos) begin
          if (!r_full[r_fill_sel]) begin
            w_fill_wr = 1'b1;
            if (stream_eos) w_fill_done   = 1'b1;
            else            w_fill_stays_note(w_fstate_next);
          end else begin
            w_fill_ovf = 1'b1;
          end
        end
      end
      F_FILL: begin
        // A repeated sos simply restarts into the same bank: nothing to reset
        w_fill_wr = 1'b1;
        if (stream_eos) begin
          w_fill_done   = 1'b1;
          w_fstate_next = F_IDLE;
        end
      end
      default: w_fstate_next = F_IDLE;
    endcase
  end

  // Small helper so the F_IDLE branch reads as "enter fill"
  function automatic void w_fill_stays_note(output fill_state_t st);
    st = F_FILL;
  endfunction

  assign fill_ready = (r_fstate == F_IDLE) & ~r_full[r_fill_sel];

  // Release is immediate when idle, otherwise held until the burst's last issue
  assign w_rel_now  = (rd_release & w_rd_idle & ~w_rd_multi & r_full[r_read_sel])
                    | (w_rd_last & (r_pend_rel | rd_release));
  assign w_pend_set = rd_release & ~w_rel_now & (~w_rd_idle | w_rd_multi);

  // Completion and release always concern different banks, so both may apply
  always_comb begin
    w_full_next = r_full;
    if (w_fill_done) w_full_next[r_fill_sel] = 1'b1;
    if (w_rel_now)   w_full_next[r_read_sel] = 1'b0;
  end

  // Bank bookkeeping and fill state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fstate       <= F_IDLE;
      r_full         <= 2'b00;
      r_fill_sel     <= 1'b0;
      r_read_sel     <= 1'b0;
      r_pend_rel     <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_fstate <= w_fstate_next;
      r_full   <= w_full_next;
      if (w_fill_done) r_fill_sel <= ~r_fill_sel;
      if (w_rel_now)   r_read_sel <= ~r_read_sel;
      if (w_rel_now)       r_pend_rel <= 1'b0;
      else if (w_pend_set) r_pend_rel <= 1'b1;
      if (w_fill_ovf) r_overflow_err <= 1'b1;
    end
  end

  assign overflow_err = r_overflow_err;

  sm_fv_rd_burst #(
    .BANK_AW        (BANK_AW),
    .NODE_W         (NODE_W),
    .LN_W           (LN_W),
    .TAG_W          (TAG_W),
    .LINES_PER_NODE (LINES_PER_NODE)
  ) u_rd_burst (
    .clk            (clk),
    .reset          (reset),
    .i_req_valid    (rd_req_valid),
    .i_bank_full    (r_full[r_read_sel]),
    .i_req_node     (rd_req_node),
    .i_req_lines    (rd_req_lines),
    .i_req_tag      (rd_req_tag),
    .i_read_sel     (r_read_sel),
    .o_req_ready    (rd_req_ready),
    .o_issue        (w_rd_issue),
    .o_issue_addr   (w_rd_addr),
    .o_idle         (w_rd_idle),
    .o_multi_accept (w_rd_multi),
    .o_burst_last   (w_rd_last),
    .o_out_valid    (rd_out_valid),
    .o_out_sos      (rd_out_sos),
    .o_out_eos      (rd_out_eos),
    .o_out_tag      (rd_out_tag),
    .o_out_bank     (w_out_bank)
  );

  // Per-bank SRAM controls: fill side writes, read side reads, never the same bank
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK_ID = (gi == 1);
    logic w_fill_hit, w_read_hit;
    assign w_fill_hit      = w_fill_wr  & (r_fill_sel == BANK_ID);
    assign w_read_hit      = w_rd_issue & (r_read_sel == BANK_ID);
    assign sram_cen[gi]    = ~(w_fill_hit | w_read_hit);
    assign sram_wen[gi]    = ~w_fill_hit;
    assign w_bank_addr[gi] = w_fill_hit ? w_fill_addr : (w_read_hit ? w_rd_addr : '0);
  end

  assign sram_addr0  = w_bank_addr[0];
  assign sram_addr1  = w_bank_addr[1];
  assign sram_wdata  = w_fill_wr ? stream_data : '0;
  assign rd_out_data = rd_out_valid ? (w_out_bank ? sram_rdata1 : sram_rdata0) : '0;

endmodule
